// File: rtl/ibex_trace_buf_pkg.sv
// ibex_trace_buf_pkg
// Shared types for the Ibex instruction trace buffer:
//   trace_rec_t   - packed 103-bit retirement record {pc, insn, rd_addr, rd_wdata, trap, intr}
//   trace_mode_e  - capture mode (STOP / WRAP / TRIG; encoding 3 is reserved)
//   trace_state_e - controller state
//   TraceRecW     - record width in bits
//   decode_mode() - folds the reserved mode encoding onto STOP
package ibex_trace_buf_pkg;

  localparam int unsigned TraceRecW = 103;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_WRAP = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } trace_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  function automatic trace_mode_e decode_mode(logic [1:0] m);
    return (m == 2'd3) ? MODE_STOP : trace_mode_e'(m);
  endfunction

endpackage

// File: rtl/ibex_trace_buf_mem.sv
// ibex_trace_buf_mem
// Depth x TraceRecW record storage: one write port, one registered read port.
//   i_clk, i_rst      clock, synchronous active-high reset (clears read register only)
//   i_we/i_waddr/i_wdata  write port
//   i_raddr           read address (the controller's next read pointer)
//   o_rdata           registered read data
module ibex_trace_buf_mem
  import ibex_trace_buf_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [AddrW-1:0]     i_waddr,
  input  logic [TraceRecW-1:0] i_wdata,
  input  logic [AddrW-1:0]     i_raddr,
  output logic [TraceRecW-1:0] o_rdata
);

  logic [TraceRecW-1:0] r_mem [Depth];
  logic [TraceRecW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-through bypass so a record pushed into the read slot is visible
  // on the very next cycle instead of one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ibex_trace_buffer.sv
// ibex_trace_buffer
// Captures RVFI retirements as compact trace records in a circular buffer
// and drains them over a valid/ready stream.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, stop_i, clear_i     capture control pulses
//   mode_i, post_count_i         capture mode / post-trigger count (sampled on start)
//   trig_i, trig_pc_en_i, trig_pc_i   external and PC-match triggers
//   filt_lo_i, filt_hi_i         inclusive PC filter window
//   rvfi_*                       retirement stream from the core
//   out_valid_o/out_ready_i/out_data_o  record readout stream
//   count_o, dropped_o, triggered_o, done_o  status
// Optional feature: define IBEX_TRACE_BUF_FILTER_EN to enable the PC filter.
module ibex_trace_buffer
  import ibex_trace_buf_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned CntW  = $clog2(Depth) + 1,
  parameter int unsigned DropW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  input  logic [1:0]           mode_i,
  input  logic [CntW-1:0]      post_count_i,
  input  logic                 trig_i,
  input  logic                 trig_pc_en_i,
  input  logic [31:0]          trig_pc_i,
  input  logic [31:0]          filt_lo_i,
  input  logic [31:0]          filt_hi_i,
  input  logic                 rvfi_valid,
  input  logic                 rvfi_trap,
  input  logic                 rvfi_intr,
  input  logic [31:0]          rvfi_pc_rdata,
  input  logic [31:0]          rvfi_insn,
  input  logic [31:0]          rvfi_rd_wdata,
  input  logic [4:0]           rvfi_rd_addr,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [TraceRecW-1:0] out_data_o,
  output logic [CntW-1:0]      count_o,
  output logic [DropW-1:0]     dropped_o,
  output logic                 triggered_o,
  output logic                 done_o
);

  localparam int unsigned     PtrW    = $clog2(Depth);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
  localparam logic [CntW-1:0] MaxPost = CntW'(Depth - 1);

  trace_state_e     r_state, w_state_next;
  trace_mode_e      r_mode;
  logic [CntW-1:0]  r_post_cnt, r_post_left, w_post_left_next;
  logic             r_trig_pend, w_trig_pend_next;
  logic             r_triggered, w_triggered_next;
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_next, w_rd_ptr_next;
  logic [CntW-1:0]  r_count;
  logic [DropW-1:0] r_dropped;

  logic w_active, w_start, w_restart, w_pc_match, w_filt_ok;
  logic w_push_req, w_full, w_stop_mode, w_out_valid, w_pop;
  logic w_wr, w_drop, w_ovf;
  trace_rec_t w_rec;
  logic [CntW-1:0] w_post_sat;

`ifdef IBEX_TRACE_BUF_FILTER_EN
  assign w_filt_ok = (rvfi_pc_rdata >= filt_lo_i) && (rvfi_pc_rdata <= filt_hi_i);
`else
  logic w_unused_filt;
  assign w_unused_filt = ^{filt_lo_i, filt_hi_i};
  assign w_filt_ok     = 1'b1;
`endif

  assign w_rec = '{pc: rvfi_pc_rdata, insn: rvfi_insn, rd_addr: rvfi_rd_addr,
                   rd_wdata: rvfi_rd_wdata, trap: rvfi_trap, intr: rvfi_intr};

  assign w_active    = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_start     = start_i && !clear_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_restart   = clear_i || w_start;
  assign w_pc_match  = rvfi_valid && trig_pc_en_i && (rvfi_pc_rdata == trig_pc_i);
  assign w_push_req  = rvfi_valid && w_active && w_filt_ok && !clear_i;
  assign w_full      = (r_count == FullCnt);
  assign w_stop_mode = (r_mode == MODE_STOP);
  // Overwriting modes move the read pointer while capturing, so readout is
  // held off until capture ends.
  assign w_out_valid = (r_count != '0) && (w_stop_mode || !w_active);
  assign w_pop       = w_out_valid && out_ready_i;
  assign w_wr        = w_push_req && (!w_full || w_pop || !w_stop_mode);
  assign w_drop      = w_push_req && w_full && !w_pop && w_stop_mode;
  assign w_ovf       = w_wr && w_full && !w_pop;
  assign w_post_sat  = (post_count_i > MaxPost) ? MaxPost : post_count_i;

  assign w_wr_ptr_next = w_restart ? '0 : r_wr_ptr + PtrW'(w_wr);
  assign w_rd_ptr_next = w_restart ? '0 : r_rd_ptr + PtrW'(w_pop || w_ovf);

  // r_trig_pend: an external trigger arrived but its trigger record (the
  // next stored one) has not been stored yet; it does not use a post count.
  always_comb begin
    w_state_next     = r_state;
    w_trig_pend_next = r_trig_pend;
    w_post_left_next = r_post_left;
    w_triggered_next = r_triggered;
    if (clear_i) begin
      w_state_next     = ST_IDLE;
      w_trig_pend_next = 1'b0;
      w_post_left_next = '0;
      w_triggered_next = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            w_state_next     = ST_CAPTURE;
            w_trig_pend_next = 1'b0;
            w_post_left_next = '0;
            w_triggered_next = 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (stop_i) begin
            w_state_next = ST_DONE;
          end else if ((r_mode == MODE_TRIG) && (trig_i || w_pc_match)) begin
            w_triggered_next = 1'b1;
            w_post_left_next = r_post_cnt;
            if (trig_i && !w_pc_match && !w_push_req) begin
              w_trig_pend_next = 1'b1;
              w_state_next     = ST_POST;
            end else if (r_post_cnt == '0) begin
              w_state_next = ST_DONE;
            end else begin
              w_state_next = ST_POST;
            end
          end
        end
        ST_POST: begin
          if (w_push_req) begin
            if (r_trig_pend) begin
              w_trig_pend_next = 1'b0;
              if (r_post_cnt == '0) w_state_next = ST_DONE;
            end else begin
              w_post_left_next = r_post_left - CntW'(1);
              if (r_post_left <= CntW'(1)) w_state_next = ST_DONE;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_trig_pend <= 1'b0;
      r_post_left <= '0;
      r_triggered <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_trig_pend <= w_trig_pend_next;
      r_post_left <= w_post_left_next;
      r_triggered <= w_triggered_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_dropped  <= '0;
      r_mode     <= MODE_STOP;
      r_post_cnt <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      if (w_restart) begin
        r_count   <= '0;
        r_dropped <= '0;
      end else begin
        if (w_wr && !w_pop && !w_full) begin
          r_count <= r_count + CntW'(1);
        end else if (w_pop && !w_wr) begin
          r_count <= r_count - CntW'(1);
        end
        if (w_drop && (r_dropped != '1)) begin
          r_dropped <= r_dropped + DropW'(1);
        end
      end
      if (w_start) begin
        r_mode     <= decode_mode(mode_i);
        r_post_cnt <= w_post_sat;
      end
    end
  end

  ibex_trace_buf_mem #(
    .Depth (Depth)
  ) u_mem (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_rec),
    .i_raddr (w_rd_ptr_next),
    .o_rdata (out_data_o)
  );

  assign out_valid_o = w_out_valid;
  assign count_o     = r_count;
  assign dropped_o   = r_dropped;
  assign triggered_o = r_triggered;
  assign done_o      = (r_state == ST_DONE);

endmodule

// File: tb/tb_ibex_trace_buffer.sv
module tb_ibex_trace_buffer;
  import ibex_trace_buf_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNTW  = 5;

  // Spec state names for the reference model.
  localparam int S_IDLE = 0, S_CAP = 1, S_POST = 2, S_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, start_i, stop_i, clear_i, trig_i, trig_pc_en_i;
  logic [1:0] mode_i;
  logic [CNTW-1:0] post_count_i;
  logic [31:0] trig_pc_i, filt_lo_i, filt_hi_i;
  logic rvfi_valid, rvfi_trap, rvfi_intr;
  logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata;
  logic [4:0] rvfi_rd_addr;
  logic out_valid_o, out_ready_i, triggered_o, done_o;
  logic [TraceRecW-1:0] out_data_o;
  logic [CNTW-1:0] count_o;
  logic [15:0] dropped_o;

  ibex_trace_buffer #(.Depth(DEPTH), .DropW(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .mode_i(mode_i), .post_count_i(post_count_i), .trig_i(trig_i),
    .trig_pc_en_i(trig_pc_en_i), .trig_pc_i(trig_pc_i),
    .filt_lo_i(filt_lo_i), .filt_hi_i(filt_hi_i),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_rd_addr(rvfi_rd_addr),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o), .dropped_o(dropped_o), .triggered_o(triggered_o), .done_o(done_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queue based) ----------------
  trace_rec_t m_q[$];
  int  m_st = S_IDLE, m_mode = 0, m_postcnt = 0, m_after = 0;
  int  m_drop = 0;
  bit  m_trig = 0, m_pend = 0, m_live = 0;

  function automatic bit m_valid();
    return (m_q.size() != 0) && (m_mode == 0 || !(m_st == S_CAP || m_st == S_POST));
  endfunction

  function automatic bit m_filt(logic [31:0] pc);
`ifdef IBEX_TRACE_BUF_FILTER_EN
    return (pc >= filt_lo_i) && (pc <= filt_hi_i);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    bit pop, act, elig, pcm;
    trace_rec_t rec;
    pop = m_valid() && out_ready_i;
    rec = {rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata, rvfi_trap, rvfi_intr};
    if (rst_i) begin
      m_q.delete(); m_st = S_IDLE; m_mode = 0; m_drop = 0; m_trig = 0; m_pend = 0;
      m_live = 1;
    end else if (clear_i) begin
      m_q.delete(); m_st = S_IDLE; m_drop = 0; m_trig = 0; m_pend = 0;
    end else if (start_i && (m_st == S_IDLE || m_st == S_DONE)) begin
      m_q.delete(); m_st = S_CAP; m_drop = 0; m_trig = 0; m_pend = 0;
      m_mode = (mode_i == 2'd3) ? 0 : int'(mode_i);
      m_postcnt = (int'(post_count_i) > DEPTH - 1) ? DEPTH - 1 : int'(post_count_i);
    end else begin
      if (pop) void'(m_q.pop_front());
      act  = (m_st == S_CAP || m_st == S_POST);
      elig = rvfi_valid && act && m_filt(rvfi_pc_rdata);
      pcm  = rvfi_valid && trig_pc_en_i && (rvfi_pc_rdata == trig_pc_i);
      if (elig) begin
        if (m_q.size() < DEPTH) m_q.push_back(rec);
        else if (m_mode == 0) begin if (m_drop != 65535) m_drop++; end
        else begin void'(m_q.pop_front()); m_q.push_back(rec); end
      end
      if (m_st == S_CAP) begin
        if (stop_i) m_st = S_DONE;
        else if (m_mode == 2 && (trig_i || pcm)) begin
          m_trig = 1; m_after = 0;
          m_pend = !(pcm || elig);
          m_st = (!m_pend && m_postcnt == 0) ? S_DONE : S_POST;
        end
      end else if (m_st == S_POST && elig) begin
        if (m_pend) m_pend = 0; else m_after++;
        if (!m_pend && m_after == m_postcnt) m_st = S_DONE;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] pop_log[$];
  always @(negedge clk) begin
    trace_rec_t d;
    if (m_live) begin
      chk("count", 128'(count_o), 128'(m_q.size()));
      chk("out_valid", 128'(out_valid_o), 128'(m_valid()));
      chk("dropped", 128'(dropped_o), 128'(m_drop));
      chk("triggered", 128'(triggered_o), 128'(m_trig));
      chk("done", 128'(done_o), 128'(m_st == S_DONE));
      if (m_valid() && m_q.size() != 0) chk("out_data", 128'(out_data_o), 128'(m_q[0]));
      d = out_data_o;
      if (out_valid_o && out_ready_i) pop_log.push_back(d.pc);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] pcf(int i);
    return 32'h1000 + 32'(i) * 4;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rec(int i, logic [31:0] pc);
    rvfi_pc_rdata = pc;
    rvfi_insn     = 32'h0000_0013 ^ (32'(i) << 7);
    rvfi_rd_addr  = 5'(i);
    rvfi_rd_wdata = 32'hA5A5_0000 + 32'(i);
    rvfi_trap     = (i % 7 == 3);
    rvfi_intr     = (i % 5 == 2);
  endtask

  task automatic retire(int i);
    set_rec(i, pcf(i)); rvfi_valid = 1; tick(); rvfi_valid = 0;
  endtask

  task automatic pulse_start(logic [1:0] m, int post);
    mode_i = m; post_count_i = CNTW'(post); start_i = 1; tick(); start_i = 0;
  endtask

  task automatic pulse_stop();  stop_i = 1;  tick(); stop_i = 0;  endtask
  task automatic pulse_clear(); clear_i = 1; tick(); clear_i = 0; endtask

  task automatic drain(int max_cyc);
    int k = 0;
    out_ready_i = 1;
    while (count_o != 0 && k < max_cyc) begin tick(); k++; end
    out_ready_i = 0;
    chk("drain_bound", 128'(count_o), 128'(0));
  endtask

  task automatic check_pops(string name, int first, int n);
    chk({name, "_npop"}, 128'(pop_log.size()), 128'(n));
    for (int k = 0; k < n && k < pop_log.size(); k++)
      chk({name, "_pc"}, 128'(pop_log[k]), 128'(pcf(first + k)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; start_i = 0; stop_i = 0; clear_i = 0; trig_i = 0; trig_pc_en_i = 0;
    mode_i = 0; post_count_i = '0; trig_pc_i = '0; filt_lo_i = 32'h0; filt_hi_i = 32'hFFFF_FFFF;
    rvfi_valid = 0; out_ready_i = 0; set_rec(0, 32'h0);
    tick(); tick(); tick();
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_valid", 128'(out_valid_o), 128'(0));
    chk("rst_data", 128'(out_data_o), 128'(0));
    rst_i = 0; tick();

    // STOP: 20 retirements, no reads
    pulse_start(2'd0, 0);
    for (int i = 0; i < 20; i++) retire(i);
    chk("stop_count", 128'(count_o), 128'(16));
    chk("stop_dropped", 128'(dropped_o), 128'(4));
    pulse_stop();
    pop_log.delete(); drain(40); check_pops("stop", 0, 16);

    // WRAP from DONE; retirement alongside start must not be stored
    set_rec(999, 32'hDEAD_0000); rvfi_valid = 1;
    pulse_start(2'd1, 0); rvfi_valid = 0;
    for (int i = 0; i < 20; i++) retire(i);
    chk("wrap_count", 128'(count_o), 128'(16));
    chk("wrap_valid_capture", 128'(out_valid_o), 128'(0));
    pulse_stop();
    pop_log.delete(); drain(40); check_pops("wrap", 4, 16);
    pulse_clear();

    // TRIG: PC match on record 10, post 3
    trig_pc_en_i = 1; trig_pc_i = pcf(10);
    pulse_start(2'd2, 3);
    for (int i = 0; i < 30; i++) retire(i);
    chk("trig_done", 128'(done_o), 128'(1));
    chk("trig_triggered", 128'(triggered_o), 128'(1));
    chk("trig_count", 128'(count_o), 128'(14));
    pop_log.delete(); drain(40); check_pops("trig", 0, 14);
    trig_pc_en_i = 0; pulse_clear();

    // STOP full with push and pop every cycle
    pulse_start(2'd0, 0);
    for (int i = 100; i < 116; i++) retire(i);
    pop_log.delete();
    out_ready_i = 1;
    for (int i = 116; i < 136; i++) retire(i);
    out_ready_i = 0;
    chk("pp_count", 128'(count_o), 128'(16));
    chk("pp_dropped", 128'(dropped_o), 128'(0));
    pulse_stop();
    drain(40); check_pops("pp", 100, 36);
    pulse_clear();

    // clear mid-POST together with a retirement
    pulse_start(2'd2, 5);
    for (int i = 200; i < 203; i++) retire(i);
    trig_i = 1; retire(203); trig_i = 0;
    retire(204);
    chk("post_triggered", 128'(triggered_o), 128'(1));
    chk("post_done", 128'(done_o), 128'(0));
    clear_i = 1; retire(205); clear_i = 0;
    chk("clr_count", 128'(count_o), 128'(0));
    chk("clr_valid", 128'(out_valid_o), 128'(0));
    chk("clr_triggered", 128'(triggered_o), 128'(0));
    retire(206);
    chk("idle_no_store", 128'(count_o), 128'(0));

    // post count saturates at Depth-1; trigger on first record
    trig_pc_en_i = 1; trig_pc_i = pcf(300);
    pulse_start(2'd2, 31);
    for (int i = 300; i < 320; i++) retire(i);
    chk("sat_done", 128'(done_o), 128'(1));
    chk("sat_count", 128'(count_o), 128'(16));
    pop_log.delete(); drain(40); check_pops("sat", 300, 16);
    trig_pc_en_i = 0; pulse_clear();

    // external trigger with post 0: next stored record ends capture
    pulse_start(2'd2, 0);
    retire(400);
    trig_i = 1; tick(); trig_i = 0;
    retire(401); retire(402);
    chk("p0_done", 128'(done_o), 128'(1));
    chk("p0_count", 128'(count_o), 128'(2));
    pop_log.delete(); drain(10); check_pops("p0", 400, 2);
    pulse_clear();

    // reserved mode behaves as STOP; start ignored while capturing
    pulse_start(2'd3, 0);
    for (int i = 500; i < 518; i++) begin
      if (i == 505) start_i = 1;
      retire(i);
      start_i = 0;
    end
    chk("rsvd_count", 128'(count_o), 128'(16));
    chk("rsvd_dropped", 128'(dropped_o), 128'(2));
    pop_log.delete(); drain(40); check_pops("rsvd", 500, 16);
    pulse_clear();

`ifdef IBEX_TRACE_BUF_FILTER_EN
    filt_lo_i = 32'h100; filt_hi_i = 32'h1FF;
    pulse_start(2'd0, 0);
    for (int i = 0; i < 19; i++) begin
      set_rec(i, 32'h0F0 + 32'(i) * 32'h10); rvfi_valid = 1; tick(); rvfi_valid = 0;
    end
    chk("filt_count", 128'(count_o), 128'(16));
    chk("filt_dropped", 128'(dropped_o), 128'(0));
    pulse_clear();
    filt_lo_i = 32'h0; filt_hi_i = 32'hFFFF_FFFF;
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_trace_buffer.md
# ibex_trace_buffer

On-chip instruction trace capture unit for the Ibex TL-UL subsystem. It consumes the core's RVFI retirement stream and stores compact retirement records in a parametrised circular buffer. It supports three capture modes: stop-when-full, wrap, and triggered with post-trigger count. Records drain through a valid/ready stream to a debug or readout agent, so simulation-only text tracing is no longer the only trace path.

## Interface
Parameters:
- Depth, 16: buffer entries; power of two, 4..256.
- CntW, $clog2(Depth)+1: width of count and post-count fields (derived; not overridden).
- DropW, 16: width of the dropped-record counter.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  pulse: begin capture (pointers cleared, post_count_i and mode_i sampled).
- stop_i  in  1  pulse: end capture.
- clear_i  in  1  pulse: return to IDLE, empty buffer, zero counters.
- mode_i  in  2  0 = STOP (FIFO, drop when full); 1 = WRAP (overwrite oldest); 2 = TRIG; 3 reserved, treated as STOP.
- post_count_i  in  CntW  records captured after the trigger record; saturates at Depth-1.
- trig_i  in  1  external trigger pulse.
- trig_pc_en_i  in  1  enables PC-match trigger.
- trig_pc_i  in  32  trigger PC.
- filt_lo_i, filt_hi_i  in  32 each  inclusive PC filter window (see Configuration).
- rvfi_valid, rvfi_trap, rvfi_intr  in  1 each  retirement strobe and flags.
- rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata  in  32 each.
- rvfi_rd_addr  in  5.
- out_valid_o  out  1  oldest record available.
- out_ready_i  in  1  consumer accepts record.
- out_data_o  out  103  trace_rec_t {pc, insn, rd_addr, rd_wdata, trap, intr}.
- count_o  out  CntW  entries held.
- dropped_o  out  DropW  records lost in STOP mode; saturating.
- triggered_o  out  1  trigger seen in current capture.
- done_o  out  1  state == DONE.

## Operation
- States: IDLE, CAPTURE, POST, DONE. Reset puts the block in IDLE with all pointers and counters at 0 and every output at 0.
- IDLE -> CAPTURE on start_i.
- CAPTURE -> DONE on stop_i.
- CAPTURE -> POST on trigger in TRIG mode. A trigger is trig_i, or a PC match (rvfi_valid && trig_pc_en_i && rvfi_pc_rdata == trig_pc_i).
- POST -> DONE once post_count_i records have been stored after the trigger record. With post_count_i = 0, the block enters DONE right after storing the trigger record.
- POST ignores stop_i.
- DONE -> CAPTURE on start_i, which discards contents. Any state -> IDLE on clear_i.
- Priority: rst_i > clear_i > start_i > stop_i > trigger. start_i is ignored in CAPTURE and POST.
- A record is stored when rvfi_valid is high, the state is CAPTURE or POST, and the filter passes.
- On a PC-match trigger, the matching retirement is itself the trigger record. An external trig_i applies to the next stored record. Only the first trigger per capture counts.
- Full in STOP mode: the record is dropped and dropped_o increments, saturating at all-ones.
- Full in WRAP or TRIG mode: the record overwrites the oldest entry; the read pointer advances and count_o stays at Depth.
- Readout in STOP mode: allowed in any state.
- Readout in WRAP and TRIG modes: out_valid_o is forced low in CAPTURE and POST, so pointers stay coherent; readout is allowed in IDLE (after clear it is empty) and DONE.
- A pop happens when out_valid_o && out_ready_i.
- Simultaneous push and pop (STOP mode): count_o is unchanged, and a push into a full buffer succeeds if a pop occurs in the same cycle.
- Pointers are log2(Depth) bits and wrap naturally.

## Timing
- A stored record is visible on out_data_o, count_o and out_valid_o one cycle after its rvfi_valid cycle.
- out_data_o is the registered array read at the read pointer; the next record appears the cycle after a pop.
- The state changes one cycle after start_i, stop_i or the trigger. triggered_o and done_o are registered.
- clear_i or start_i zeroes count_o, dropped_o and triggered_o on the next cycle. A retirement in the same cycle as start_i is not stored.
- out_data_o holds its value while out_valid_o && !out_ready_i.

## Configuration
- IBEX_TRACE_BUF_FILTER_EN defined: a record is eligible only if filt_lo_i <= rvfi_pc_rdata <= filt_hi_i, compared unsigned. PC-match triggers still fire on filtered-out PCs, but such a record is not stored and does not consume a post count.
- Macro undefined: every retirement is eligible; filt_lo_i and filt_hi_i are unused but the ports remain.

## Structure
- ibex_trace_buf_pkg contains: trace_rec_t (packed, 103 bits), trace_mode_e, trace_state_e, and the TraceRecW localparam.
- Sub-module ibex_trace_buf_mem: Depth x TraceRecW, one write port and one registered read port.
- The controller holds the FSM, pointers, counters and trigger logic.

## Test plan
- STOP, Depth=16: 20 retirements with no reads -> count_o=16, dropped_o=4, records 0..15 drained in order.
- WRAP: 20 retirements, stop_i -> DONE; drain yields records 4..19 and count_o reaches 0.
- TRIG, post_count_i=3, trigger PC at record 10 of 30 -> DONE after record 13; drain yields records 0..13 (14 entries), triggered_o=1.
- STOP, full buffer with simultaneous push and pop every cycle -> count_o stays 16, dropped_o=0, order preserved.
- clear_i asserted mid-POST alongside rvfi_valid -> next cycle IDLE, count_o=0, out_valid_o=0, nothing stored.
- FILTER_EN, window 0x100..0x1FF, PCs 0x0F0..0x210 in steps of 0x10 -> only the 16 in-window records stored.
